euler_writeback: RTL and testbench

Result-consumer end of the Euler matrix-vector pipeline. Takes each per-row accumulator result (`data_ready`/`acc` handshake) and reads the old state element x[i]. Computes the Euler update x[i] + h·acc in signed fixed point, writes the result back to state memory, and releases the pipeline for the next row with `return_default_state`. After `shape_0` rows it raises `final_done`, which closes the pipeline's start FSM.

---
 rtl/euler_pkg.sv | 35 +++
 rtl/euler_axpy.sv | 65 ++++++
 rtl/euler_writeback.sv | 187 ++++++++++++++++++
 tb/tb_euler_writeback.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/euler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : euler_pkg
//  Description : Shared types and constants for the Euler write-back stage.
//                Holds the write-back state encoding, the default fixed-point
//                format and helpers that derive the signed saturation bounds
//                for a given data width.
//  Revision    : 1.0  initial release
// ============================================================================
package euler_pkg;

    localparam int DATA_SIZE_DEF = 16;
    localparam int FRAC_BITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ROW = 3'd1,
        READ     = 3'd2,
        UPDATE   = 3'd3,
        WRITE    = 3'd4,
        DONE     = 3'd5
    } wb_state_t;

    // Largest representable signed value of a W-bit word, zero-extended.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative signed value of a W-bit word; only the low W bits matter.
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage : euler_pkg
`default_nettype wire

// File: rtl/euler_axpy.sv
`default_nettype none
// ============================================================================
//  Module      : euler_axpy
//  Description : Combinational signed fixed-point update s = x_old + (h*acc >>> FRAC_BITS).
//                The product is kept at full 2*DATA_SIZE width, shifted
//                arithmetically (truncation toward -inf) and added at
//                2*DATA_SIZE+1 bits before being reduced to DATA_SIZE.
//  Build macro : EULER_WB_SATURATE_EN - clamp to the signed range instead of
//                keeping the low DATA_SIZE bits.
//  Ports       : h, acc, x_old  signed DATA_SIZE operands
//                s              reduced DATA_SIZE result
//                ovf            result did not fit in DATA_SIZE signed bits
//  Revision    : 1.0  initial release
// ============================================================================
module euler_axpy
    import euler_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic signed [DATA_SIZE-1:0] h,
    input  logic signed [DATA_SIZE-1:0] acc,
    input  logic signed [DATA_SIZE-1:0] x_old,
    output logic        [DATA_SIZE-1:0] s,
    output logic                        ovf
);

    localparam int PW = 2 * DATA_SIZE;
    localparam int SW = PW + 1;

`ifdef EULER_WB_SATURATE_EN
    localparam logic [DATA_SIZE-1:0] SAT_MAX = DATA_SIZE'(sat_max(DATA_SIZE));
    localparam logic [DATA_SIZE-1:0] SAT_MIN = DATA_SIZE'(sat_min(DATA_SIZE));
`endif

    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        prod_sh;
    logic        [SW-1:0]        sum;
    logic        [SW-DATA_SIZE:0] top;
    logic                        fits;

    always_comb begin
        prod    = h * acc;
        prod_sh = prod >>> FRAC_BITS;
        sum     = {{(SW - DATA_SIZE){x_old[DATA_SIZE-1]}}, x_old}
                + {prod_sh[PW-1], prod_sh};
        // The sum fits when every bit above the result sign bit copies it.
        top     = sum[SW-1:DATA_SIZE-1];
        fits    = (&top) | ~(|top);
        ovf     = ~fits;
`ifdef EULER_WB_SATURATE_EN
        if (fits) begin
            s = sum[DATA_SIZE-1:0];
        end else if (sum[SW-1]) begin
            s = SAT_MIN;
        end else begin
            s = SAT_MAX;
        end
`else
        s = sum[DATA_SIZE-1:0];
`endif
    end

endmodule : euler_axpy
`default_nettype wire

// File: rtl/euler_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : euler_writeback
//  Description : Result-consumer end of the Euler matrix-vector pipeline.
//                For each row result it reads x[i], computes x[i] + h*acc,
//                writes it back and pulses return_default_state. After
//                shape_0 rows final_done is raised until the next start.
//  Build macro : EULER_WB_SATURATE_EN (see euler_axpy)
//  Ports       : clk, rst (async, active-low)
//                start, shape_0, base_addr, step_h   step control
//                data_ready, acc_in, ovf_in          row result from pipeline
//                rd_en, rd_addr, rd_data             state-memory read (1-cycle latency)
//                wr_en, wr_addr, wr_data             state-memory write
//                return_default_state                per-row release pulse
//                final_done, overflow                step status
//  Revision    : 1.0  initial release
// ============================================================================
module euler_writeback
    import euler_pkg::*;
#(
    parameter int ADD_SIZE  = 16,
    parameter int DATA_SIZE = 16,
    parameter int MAX_DIM   = 6,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MAX_DIM-1:0]   shape_0,
    input  logic [ADD_SIZE-1:0]  base_addr,
    input  logic [DATA_SIZE-1:0] step_h,
    input  logic                 data_ready,
    input  logic [DATA_SIZE-1:0] acc_in,
    input  logic                 ovf_in,
    output logic                 rd_en,
    output logic [ADD_SIZE-1:0]  rd_addr,
    input  logic [DATA_SIZE-1:0] rd_data,
    output logic                 wr_en,
    output logic [ADD_SIZE-1:0]  wr_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic                 return_default_state,
    output logic                 final_done,
    output logic                 overflow
);

    wb_state_t            state_q, state_d;
    logic [MAX_DIM-1:0]   row_q, row_d;
    logic [MAX_DIM-1:0]   shape_q, shape_d;
    logic [ADD_SIZE-1:0]  base_q, base_d;
    logic [DATA_SIZE-1:0] h_q, h_d;
    logic [DATA_SIZE-1:0] acc_q, acc_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADD_SIZE-1:0]  rd_addr_q, rd_addr_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADD_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
    logic                 rds_q, rds_d;
    logic                 final_done_q, final_done_d;
    logic                 overflow_q, overflow_d;

    logic [DATA_SIZE-1:0] upd_s;
    logic                 upd_ovf;
    logic [ADD_SIZE-1:0]  row_addr;

    // rd_data is only meaningful in UPDATE, where it is the old x[i].
    euler_axpy #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC_BITS (FRAC_BITS)
    ) u_axpy (
        .h     (h_q),
        .acc   (acc_q),
        .x_old (rd_data),
        .s     (upd_s),
        .ovf   (upd_ovf)
    );

    assign row_addr = base_q + ADD_SIZE'(row_q);

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        shape_d      = shape_q;
        base_d       = base_q;
        h_d          = h_q;
        acc_d        = acc_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rds_d        = 1'b0;
        final_done_d = final_done_q;
        overflow_d   = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                // A start in DONE wins over a coincident data_ready.
                if (start) begin
                    shape_d      = shape_0;
                    base_d       = base_addr;
                    h_d          = step_h;
                    row_d        = '0;
                    overflow_d   = 1'b0;
                    final_done_d = (shape_0 == '0);
                    state_d      = (shape_0 == '0) ? DONE : WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                if (data_ready) begin
                    acc_d      = acc_in;
                    overflow_d = overflow_q | ovf_in;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = row_addr;
                    state_d    = READ;
                end
            end
            READ: begin
                state_d = UPDATE;
            end
            UPDATE: begin
                wr_data_d  = upd_s;
                overflow_d = overflow_q | upd_ovf;
                wr_en_d    = 1'b1;
                wr_addr_d  = row_addr;
                rds_d      = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                if (row_q == shape_q - MAX_DIM'(1)) begin
                    final_done_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    row_d   = row_q + MAX_DIM'(1);
                    state_d = WAIT_ROW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            shape_q      <= '0;
            base_q       <= '0;
            h_q          <= '0;
            acc_q        <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rds_q        <= 1'b0;
            final_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            shape_q      <= shape_d;
            base_q       <= base_d;
            h_q          <= h_d;
            acc_q        <= acc_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rds_q        <= rds_d;
            final_done_q <= final_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rd_en                = rd_en_q;
    assign rd_addr              = rd_addr_q;
    assign wr_en                = wr_en_q;
    assign wr_addr              = wr_addr_q;
    assign wr_data              = wr_data_q;
    assign return_default_state = rds_q;
    assign final_done           = final_done_q;
    assign overflow             = overflow_q;

endmodule : euler_writeback
`default_nettype wire

// File: tb/tb_euler_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_euler_writeback
//  Description : Scoreboard bench for euler_writeback. The driver issues row
//                results and queues the expected read and write (address,
//                data, cycle); a monitor pops and compares on every rd_en and
//                wr_en. Expected values come from a plain-arithmetic model of
//                x + floor(h*acc / 2^8) with clamp or wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_euler_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  shape_0 = '0;
    logic [15:0] base_addr = '0;
    logic [15:0] step_h = '0;
    logic        data_ready = 1'b0;
    logic [15:0] acc_in = '0;
    logic        ovf_in = 1'b0;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        return_default_state;
    logic        final_done;
    logic        overflow;

    euler_writeback dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .shape_0              (shape_0),
        .base_addr            (base_addr),
        .step_h               (step_h),
        .data_ready           (data_ready),
        .acc_in               (acc_in),
        .ovf_in               (ovf_in),
        .rd_en                (rd_en),
        .rd_addr              (rd_addr),
        .rd_data              (rd_data),
        .wr_en                (wr_en),
        .wr_addr              (wr_addr),
        .wr_data              (wr_data),
        .return_default_state (return_default_state),
        .final_done           (final_done),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        rdq[$];
    exp_t        wrq[$];
    logic [15:0] mem     [0:65535];
    logic [15:0] model_x [0:65535];
    int          total = 0;
    int          bad   = 0;
    int          ncyc  = 0;
    bit          sticky = 1'b0;

    logic [15:0] acc_tab  [8];
    bit          ovf_tab  [8];
    int          hold_tab [8];
    int          gap_tab  [8];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // x + floor(h*acc / 256), then clamp or wrap to 16-bit signed.
    task automatic ref_update(input logic [15:0] h, input logic [15:0] acc,
                              input logic [15:0] x, output logic [15:0] s, output bit ovf);
        longint p, q, t;
        p = longint'($signed(h)) * longint'($signed(acc));
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        t = longint'($signed(x)) + q;
        ovf = (t > 32767) || (t < -32768);
`ifdef EULER_WB_SATURATE_EN
        if (t > 32767)       s = 16'h7FFF;
        else if (t < -32768) s = 16'h8000;
        else                 s = t[15:0];
`else
        s = t[15:0];
`endif
    endtask

    // Monitor + memory responder: everything sampled mid-cycle on negedge.
    bit          rd_pend = 1'b0;
    logic [15:0] rd_pa   = '0;
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rst) begin
            if (rd_en) begin
                if (rdq.size() == 0) begin
                    check("unexpected_rd_en addr", rd_addr, 17'h10000);
                end else begin
                    e = rdq.pop_front();
                    check("rd_addr", rd_addr, e.addr);
                    check("rd_cycle", ncyc, e.cyc);
                end
            end
            if (wr_en) begin
                if (wrq.size() == 0) begin
                    check("unexpected_wr_en addr", wr_addr, 17'h10000);
                end else begin
                    e = wrq.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("wr_cycle", ncyc, e.cyc);
                end
                mem[wr_addr] = wr_data;
            end
            if (wr_en || return_default_state)
                check("rds_with_wr_en", return_default_state, wr_en);
        end
        // Read data is valid only in the cycle after rd_en; garbage otherwise.
        rd_data = rd_pend ? mem[rd_pa] : 16'($urandom);
        rd_pend = rd_en && rst;
        rd_pa   = rd_addr;
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, " rd_en"}, rd_en, 0);
        check({tag, " rd_addr"}, rd_addr, 0);
        check({tag, " wr_en"}, wr_en, 0);
        check({tag, " wr_addr"}, wr_addr, 0);
        check({tag, " wr_data"}, wr_data, 0);
        check({tag, " rds"}, return_default_state, 0);
        check({tag, " final_done"}, final_done, 0);
        check({tag, " overflow"}, overflow, 0);
    endtask

    task automatic do_start(input int shape, input logic [15:0] base,
                            input logic [15:0] h, input bit dr_too);
        @(posedge clk); #1;
        start = 1'b1; shape_0 = 6'(shape); base_addr = base; step_h = h;
        data_ready = dr_too;
        @(posedge clk); #1;
        start = 1'b0; data_ready = 1'b0;
        shape_0 = 6'($urandom); base_addr = 16'($urandom); step_h = 16'($urandom);
        sticky = 1'b0;
        @(negedge clk);
        check("final_done_after_start", final_done, (shape == 0));
        check("overflow_cleared", overflow, 0);
    endtask

    task automatic run_rows(input int shape, input logic [15:0] base, input logic [15:0] h);
        logic [15:0] addr, s;
        bit          o, seen;
        int          v;
        exp_t        e;
        for (int r = 0; r < shape; r++) begin
            addr = base + 16'(r);
            ref_update(h, acc_tab[r], model_x[addr], s, o);
            repeat (gap_tab[r]) @(posedge clk);
            @(posedge clk); #1;
            data_ready = 1'b1; acc_in = acc_tab[r]; ovf_in = ovf_tab[r];
            v = ncyc;
            e.addr = addr; e.data = s; e.cyc = v + 2; rdq.push_back(e);
            e.cyc = v + 4; wrq.push_back(e);
            model_x[addr] = s;
            sticky = sticky | o | ovf_tab[r];
            // Holding data_ready past the accept cycle must not start another row.
            repeat (hold_tab[r]) begin @(posedge clk); #1; end
            data_ready = 1'b0; ovf_in = 1'b0; acc_in = 16'($urandom);
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                seen = return_default_state;
            end
            if (!seen) check("rds_timeout", 0, 1);
        end
        @(negedge clk);
        check("final_done_end", final_done, 1);
        check("overflow_sticky", overflow, sticky);
    endtask

    task automatic set_x(input logic [15:0] a, input logic [15:0] x);
        mem[a] = x; model_x[a] = x;
    endtask

    task automatic default_tabs();
        for (int i = 0; i < 8; i++) begin
            acc_tab[i] = 16'($urandom); ovf_tab[i] = 1'b0; hold_tab[i] = 1; gap_tab[i] = 0;
        end
    endtask

    initial begin
        logic [15:0] b, h;
        int          sh, v;
        exp_t        e;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom); model_x[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk) rst = 1'b1;

        // Basic update.
        default_tabs();
        set_x(16'h0040, 16'h0100); acc_tab[0] = 16'h0400;
        do_start(1, 16'h0040, 16'h0020, 1'b0);
        run_rows(1, 16'h0040, 16'h0020);
        check("basic_value", mem[16'h0040], 16'h0180);
        check("basic_overflow", overflow, 0);

        // Multi-row; start coincides with data_ready in DONE, and data_ready
        // is held through READ/UPDATE on some rows.
        default_tabs();
        hold_tab[0] = 2; hold_tab[1] = 3; hold_tab[2] = 1;
        do_start(3, 16'h0010, 16'h0013, 1'b1);
        run_rows(3, 16'h0010, 16'h0013);

        // Saturation / wrap.
        default_tabs();
        set_x(16'h0080, 16'h7F00); acc_tab[0] = 16'h7FFF;
        do_start(1, 16'h0080, 16'h0100, 1'b0);
        run_rows(1, 16'h0080, 16'h0100);
`ifdef EULER_WB_SATURATE_EN
        check("sat_value", mem[16'h0080], 16'h7FFF);
`else
        check("wrap_value", mem[16'h0080], 16'hFEFF);
`endif
        check("sat_overflow", overflow, 1);

        // Negative truncation toward -inf.
        default_tabs();
        set_x(16'h0090, 16'h0000); acc_tab[0] = 16'hFFFF;
        do_start(1, 16'h0090, 16'h0001, 1'b0);
        run_rows(1, 16'h0090, 16'h0001);
        check("neg_trunc_value", mem[16'h0090], 16'hFFFF);

        // Zero rows: done with no memory traffic (monitor flags any strobe).
        do_start(0, 16'h0100, 16'h0001, 1'b0);
        repeat (6) @(negedge clk);
        check("zero_rows_done_held", final_done, 1);

        // Reset while in UPDATE: no write, outputs cleared.
        default_tabs();
        do_start(2, 16'h0200, 16'h0100, 1'b0);
        @(posedge clk); #1;
        data_ready = 1'b1; acc_in = 16'h1234; ovf_in = 1'b1;
        v = ncyc;
        e.addr = 16'h0200; e.data = '0; e.cyc = v + 2; rdq.push_back(e);
        @(posedge clk); #1 data_ready = 1'b0; ovf_in = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        #1 check_outputs_zero("mid_update_reset");
        repeat (3) @(negedge clk);
        check("rst_hold final_done", final_done, 0);
        rst = 1'b1;
        check("no_pending_write", wrq.size(), 0);

        // Randomized steps, including address wrap-around.
        for (int n = 0; n < 16; n++) begin
            sh = $urandom_range(1, 6);
            b  = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            h  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 511)) - 16'd256
                                             : 16'($urandom);
            for (int i = 0; i < 8; i++) begin
                acc_tab[i]  = 16'($urandom);
                ovf_tab[i]  = ($urandom_range(0, 7) == 0);
                hold_tab[i] = $urandom_range(1, 3);
                gap_tab[i]  = $urandom_range(0, 2);
            end
            do_start(sh, b, h, $urandom_range(0, 1) == 1);
            run_rows(sh, b, h);
        end

        repeat (5) @(negedge clk);
        check("rd_queue_drained", rdq.size(), 0);
        check("wr_queue_drained", wrq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule : tb_euler_writeback
`default_nettype wire
